// File: rtl/mult_seq_32_bit.sv
// Sequential unsigned 32x32 multiplier (low 32 bits plus overflow flag).
// A single ripple-carry adder is time-shared by a shift-and-add FSM that stops once no multiplier bits remain.

module add_rca_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry_s;

    assign carry_s[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_fa
            assign sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry_s[32];
endmodule

module mult_seq_32_bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        overflow
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] mcand_r, mcand_s;
    logic [31:0] mplier_r, mplier_s;
    logic [31:0] acc_r, acc_s;
    logic        ovf_r, ovf_s;
    logic        busy_r, done_r;
    logic [31:0] sum_s;
    logic        cout_s;

    add_rca_32_bit u_add (
        .a   (acc_r),
        .b   (mcand_r),
        .cin (1'b0),
        .sum (sum_s),
        .cout(cout_s)
    );

    // Next-state and datapath update for the shift-and-add sequence.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        ovf_s    = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mcand_s  = X;
                    mplier_s = Y;
                    acc_s    = 32'd0;
                    ovf_s    = 1'b0;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mplier_r[0]) begin
                    acc_s = sum_s;
                    ovf_s = ovf_r | cout_s;
                end else begin
                    acc_s = acc_r;
                end
                // A multiplicand bit shifted out while higher multiplier bits remain is lost weight.
                if (mcand_r[31] && (mplier_r[31:1] != 31'd0)) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_s;
                end
                mcand_s  = {mcand_r[30:0], 1'b0};
                mplier_s = {1'b0, mplier_r[31:1]};
                if (mplier_r[31:1] == 31'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            acc_r    <= 32'd0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            ovf_r    <= ovf_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign product  = acc_r;
    assign overflow = ovf_r;
endmodule
